// File: rtl/param_data_memory.sv
// Single-port data memory for the multicycle CPU datapath: post-reset clear sequencer,
// req/ready handshake, READ_LAT-deep read pipeline with rvalid, and out-of-range detection.
module param_data_memory #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 13,
  parameter int                DEPTH    = 8192,
  parameter int                READ_LAT = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              init_busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  generate
    if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
      $error("param_data_memory: READ_LAT must be within 1..4");
    end
    if (DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
      $error("param_data_memory: DEPTH must be within 1..2**ADDR_W");
    end
  endgenerate

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] clr_cnt_reg, clr_cnt_next;
  logic              clr_last;

  assign clr_last = (clr_cnt_reg == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= ST_INIT;
      clr_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    ready        = 1'b0;
    init_busy    = 1'b0;
    case (state_reg)
      ST_INIT: begin
        init_busy    = 1'b1;
        clr_cnt_next = clr_cnt_reg + 1'b1;
        if (clr_last) state_next = ST_IDLE;
      end
      ST_IDLE: begin
        ready = 1'b1;
      end
      default: state_next = ST_INIT;
    endcase
  end

  // Full-width compare so out-of-range addresses never alias onto real words.
  logic accept, in_range;
  assign accept   = req & ready;
  assign in_range = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));

  logic              wr_en, rd_en;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [DATA_W-1:0] wr_val;

  assign wr_en  = init_busy | (accept & we & in_range);
  assign wr_idx = init_busy ? clr_cnt_reg[IDX_W-1:0] : addr[IDX_W-1:0];
  assign wr_val = init_busy ? INIT_VAL : wdata;
  assign rd_en  = accept & ~we & in_range;
  assign rd_idx = addr[IDX_W-1:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_raw_reg;

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_idx] <= wr_val;
    if (rd_en) rd_raw_reg <= mem[rd_idx];
  end

  logic vld0_reg, oor_rd_reg, err_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld0_reg   <= 1'b0;
      oor_rd_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      vld0_reg   <= accept & ~we;
      oor_rd_reg <= accept & ~we & ~in_range;
      err_reg    <= accept & ~in_range;
    end
  end

  // Stage 0 is the RAM output register; later stages only delay the sampled word.
  logic [DATA_W-1:0] stage_data [READ_LAT];
  logic              stage_vld  [READ_LAT];

  genvar gi;
  generate
    for (gi = 0; gi < READ_LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign stage_vld[gi]  = vld0_reg;
        assign stage_data[gi] = oor_rd_reg ? '0 : rd_raw_reg;
      end else begin : g_tail
        logic              v_reg;
        logic [DATA_W-1:0] d_reg;
        always_ff @(posedge clock or negedge reset_n) begin
          if (!reset_n) begin
            v_reg <= 1'b0;
            d_reg <= '0;
          end else begin
            v_reg <= stage_vld[gi-1];
            d_reg <= stage_data[gi-1];
          end
        end
        assign stage_vld[gi]  = v_reg;
        assign stage_data[gi] = d_reg;
      end
    end
  endgenerate

  logic [DATA_W-1:0] hold_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) hold_reg <= '0;
    else if (rvalid) hold_reg <= stage_data[READ_LAT-1];
  end

  assign rvalid = stage_vld[READ_LAT-1];
  assign rdata  = rvalid ? stage_data[READ_LAT-1] : hold_reg;
  assign err    = err_reg;

endmodule

// File: tb/tb_param_data_memory.sv
// Bench for param_data_memory: two instances (small/READ_LAT=4 and DEPTH=1000/READ_LAT=3)
// checked each cycle against a scoreboard model of memory contents and read due-times.
module tb_param_data_memory;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_n     [2];
  logic        req       [2];
  logic        we        [2];
  logic [7:0]  wdata     [2];
  logic        ready     [2];
  logic        rvalid    [2];
  logic        err       [2];
  logic        init_busy [2];
  logic [7:0]  rdata     [2];
  logic [4:0]  addr_a;
  logic [12:0] addr_b;

  param_data_memory #(.DATA_W(8), .ADDR_W(5), .DEPTH(16), .READ_LAT(4), .INIT_VAL(8'hA5)) dut_a (
    .clock(clock), .reset_n(rst_n[0]), .req(req[0]), .we(we[0]), .addr(addr_a), .wdata(wdata[0]),
    .ready(ready[0]), .rvalid(rvalid[0]), .rdata(rdata[0]), .err(err[0]), .init_busy(init_busy[0]));

  param_data_memory #(.DATA_W(8), .ADDR_W(13), .DEPTH(1000), .READ_LAT(3), .INIT_VAL(8'h00)) dut_b (
    .clock(clock), .reset_n(rst_n[1]), .req(req[1]), .we(we[1]), .addr(addr_b), .wdata(wdata[1]),
    .ready(ready[1]), .rvalid(rvalid[1]), .rdata(rdata[1]), .err(err[1]), .init_busy(init_busy[1]));

  int         depth_of [2] = '{16, 1000};
  int         lat_of   [2] = '{4, 3};
  logic [7:0] init_of  [2] = '{8'hA5, 8'h00};

  logic [7:0] mm        [2][1000];
  int         init_left [2];
  int         cyc       [2];
  logic       slot_v    [2][8];
  logic [7:0] slot_d    [2][8];
  logic [7:0] last_rd   [2];

  logic       exp_rvalid, exp_err, exp_ready;
  logic [7:0] exp_rdata;
  int         checks = 0;
  int         errors = 0;

  task automatic model_reset(input int d);
    init_left[d] = depth_of[d];
    for (int k = 0; k < 8; k++) slot_v[d][k] = 1'b0;
    last_rd[d] = 8'h00;
    for (int i = 0; i < depth_of[d]; i++) mm[d][i] = init_of[d];
    exp_rvalid = 1'b0; exp_err = 1'b0; exp_ready = 1'b0; exp_rdata = 8'h00;
  endtask

  // One clock of stimulus plus the model's view of what the outputs must be afterwards.
  task automatic drive_cycle(input int d, input logic r, input logic w, input int a, input logic [7:0] wd);
    logic acc;
    int   n;
    req[d] = r; we[d] = w; wdata[d] = wd;
    if (d == 0) addr_a = 5'(a); else addr_b = 13'(a);
    acc = r && (init_left[d] == 0);
    if (init_left[d] > 0) init_left[d]--;
    @(posedge clock); #1;
    cyc[d]++;
    n = cyc[d];
    if (acc) $display("dut%0d cyc %0d %s addr=%0d wdata=%h", d, n, w ? "WR" : "RD", a, wd);
    if (acc && !w) begin
      slot_v[d][(n + lat_of[d] - 1) % 8] = 1'b1;
      slot_d[d][(n + lat_of[d] - 1) % 8] = (a < depth_of[d]) ? mm[d][a] : 8'h00;
    end
    if (acc && w && a < depth_of[d]) mm[d][a] = wd;
    exp_err    = acc && (a >= depth_of[d]);
    exp_rvalid = slot_v[d][n % 8];
    if (exp_rvalid) last_rd[d] = slot_d[d][n % 8];
    slot_v[d][n % 8] = 1'b0;
    exp_rdata = last_rd[d];
    exp_ready = (init_left[d] == 0);
    req[d] = 1'b0;
  endtask

  task automatic test_reset(input int d);
    rst_n[d] = 1'b0;
    #1;
    model_reset(d);
    checks++;
    if (ready[d] !== 1'b0 || rvalid[d] !== 1'b0 || err[d] !== 1'b0 || init_busy[d] !== 1'b1 || rdata[d] !== 8'h00) begin
      errors++;
      $display("FAIL reset_state dut%0d: ready=%b rvalid=%b err=%b init_busy=%b rdata=%h, expected 0 0 0 1 00",
               d, ready[d], rvalid[d], err[d], init_busy[d], rdata[d]);
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic test_init(input int d, input logic hold_req);
    int count = 0;
    rst_n[d] = 1'b1;
    while (count < depth_of[d] + 8) begin
      drive_cycle(d, hold_req, 1'b1, 5, 8'h11);
      count++;
      checks++;
      if (ready[d] !== exp_ready || init_busy[d] !== !exp_ready || rvalid[d] !== 1'b0 || err[d] !== 1'b0) begin
        errors++;
        $display("FAIL init_seq dut%0d cycle %0d: ready=%b init_busy=%b rvalid=%b err=%b, expected ready=%b",
                 d, count, ready[d], init_busy[d], rvalid[d], err[d], exp_ready);
      end
      if (ready[d] === 1'b1) break;
    end
    checks++;
    if (count != depth_of[d]) begin
      errors++;
      $display("FAIL init_length dut%0d: ready after %0d cycles, expected %0d", d, count, depth_of[d]);
    end
  endtask

  task automatic test_clear_contents(input int d, input int span);
    int seen = 0;
    for (int i = 0; i < span + lat_of[d]; i++) begin
      if (i < span) drive_cycle(d, 1'b1, 1'b0, i, 8'h00);
      else drive_cycle(d, 1'b0, 1'b0, 0, 8'h00);
      checks++;
      if (rvalid[d] !== exp_rvalid || rdata[d] !== exp_rdata || err[d] !== exp_err || ready[d] !== exp_ready) begin
        errors++;
        $display("FAIL clear_read dut%0d step %0d: rvalid=%b rdata=%h err=%b, expected %b %h %b",
                 d, i, rvalid[d], rdata[d], err[d], exp_rvalid, exp_rdata, exp_err);
      end
      if (rvalid[d] === 1'b1) begin
        seen++;
        checks++;
        if (rdata[d] !== init_of[d]) begin
          errors++;
          $display("FAIL clear_value dut%0d: rdata=%h, expected %h", d, rdata[d], init_of[d]);
        end
      end
    end
    checks++;
    if (seen != span) begin
      errors++;
      $display("FAIL clear_count dut%0d: %0d rvalid pulses, expected %0d", d, seen, span);
    end
  endtask

  task automatic test_out_of_range(input int d);
    int         ta [8];
    logic       tw [8];
    logic [7:0] td [8];
    int         nops, err_seen = 0, err_exp = 0;
    if (d == 0) begin
      ta = '{15, 20, 16, 4, 20, 16, 15, 31};
      tw = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      td = '{8'h15, 8'h77, 8'h99, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      nops = 8;
    end else begin
      ta = '{999, 1005, 1005, 999, 1000, 1000, 8191, 0};
      tw = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      td = '{8'h3C, 8'hFF, 8'h00, 8'h00, 8'h12, 8'h00, 8'h00, 8'h00};
      nops = 7;
    end
    for (int i = 0; i < nops; i++) if (ta[i] >= depth_of[d]) err_exp++;
    for (int i = 0; i < nops + lat_of[d]; i++) begin
      if (i < nops) drive_cycle(d, 1'b1, tw[i], ta[i], td[i]);
      else drive_cycle(d, 1'b0, 1'b0, 0, 8'h00);
      if (err[d] === 1'b1) err_seen++;
      checks++;
      if (rvalid[d] !== exp_rvalid || rdata[d] !== exp_rdata || err[d] !== exp_err) begin
        errors++;
        $display("FAIL out_of_range dut%0d step %0d: rvalid=%b rdata=%h err=%b, expected %b %h %b",
                 d, i, rvalid[d], rdata[d], err[d], exp_rvalid, exp_rdata, exp_err);
      end
    end
    checks++;
    if (err_seen != err_exp) begin
      errors++;
      $display("FAIL err_count dut%0d: %0d err pulses, expected %0d", d, err_seen, err_exp);
    end
  endtask

  task automatic test_read_after_write(input int d);
    int steps;
    drive_cycle(d, 1'b1, 1'b1, 998, 8'd40);
    drive_cycle(d, 1'b1, 1'b0, 998, 8'h00);
    steps = 1;
    while (rvalid[d] !== 1'b1 && steps < 8) begin
      drive_cycle(d, 1'b0, 1'b0, 0, 8'h00);
      steps++;
    end
    checks++;
    if (steps != lat_of[d] || rdata[d] !== 8'd40) begin
      errors++;
      $display("FAIL raw_latency dut%0d: rvalid after %0d cycles rdata=%0d, expected %0d cycles rdata=40",
               d, steps, rdata[d], lat_of[d]);
    end
    drive_cycle(d, 1'b0, 1'b0, 0, 8'h00);
    checks++;
    if (rvalid[d] !== 1'b0 || rdata[d] !== 8'd40) begin
      errors++;
      $display("FAIL raw_pulse dut%0d: rvalid=%b rdata=%0d, expected 0 and held 40", d, rvalid[d], rdata[d]);
    end
  endtask

  task automatic test_back_to_back(input int d);
    int got = 0, first = -1, last = -1;
    for (int i = 0; i < 10; i++) drive_cycle(d, 1'b1, 1'b1, 900 + i, 8'(40 + i));
    for (int i = 0; i < 10 + lat_of[d] + 2; i++) begin
      if (i < 10) drive_cycle(d, 1'b1, 1'b0, 900 + i, 8'h00);
      else drive_cycle(d, 1'b0, 1'b0, 0, 8'h00);
      checks++;
      if (rvalid[d] !== exp_rvalid || rdata[d] !== exp_rdata || err[d] !== exp_err) begin
        errors++;
        $display("FAIL b2b_model dut%0d step %0d: rvalid=%b rdata=%h, expected %b %h",
                 d, i, rvalid[d], rdata[d], exp_rvalid, exp_rdata);
      end
      if (rvalid[d] === 1'b1) begin
        if (first < 0) first = i;
        last = i;
        checks++;
        if (rdata[d] !== 8'(40 + got)) begin
          errors++;
          $display("FAIL b2b_order dut%0d: beat %0d rdata=%0d, expected %0d", d, got, rdata[d], 40 + got);
        end
        got++;
      end
    end
    checks++;
    if (got != 10 || last - first != 9) begin
      errors++;
      $display("FAIL b2b_stream dut%0d: %0d beats over %0d cycles, expected 10 over 10", d, got, last - first + 1);
    end
  endtask

  task automatic test_random(input int d, input int n, input int amax);
    for (int i = 0; i < n + lat_of[d]; i++) begin
      if (i < n) drive_cycle(d, $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, amax), 8'($urandom));
      else drive_cycle(d, 1'b0, 1'b0, 0, 8'h00);
      checks++;
      if (rvalid[d] !== exp_rvalid || rdata[d] !== exp_rdata || err[d] !== exp_err || ready[d] !== exp_ready) begin
        errors++;
        $display("FAIL random dut%0d step %0d: rvalid=%b rdata=%h err=%b ready=%b, expected %b %h %b %b",
                 d, i, rvalid[d], rdata[d], err[d], ready[d], exp_rvalid, exp_rdata, exp_err, exp_ready);
      end
    end
  endtask

  task automatic test_reset_inflight(input int d);
    int pulses = 0;
    drive_cycle(d, 1'b1, 1'b1, 7, 8'h42);
    drive_cycle(d, 1'b1, 1'b0, 7, 8'h00);
    drive_cycle(d, 1'b1, 1'b0, 7, 8'h00);
    rst_n[d] = 1'b0;
    model_reset(d);
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      if (rvalid[d] !== 1'b0) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL inflight_discard dut%0d: %0d rvalid cycles during reset, expected 0", d, pulses);
    end
    test_init(d, 1'b0);
    drive_cycle(d, 1'b1, 1'b0, 7, 8'h00);
    for (int i = 1; i < lat_of[d]; i++) drive_cycle(d, 1'b0, 1'b0, 0, 8'h00);
    checks++;
    if (rvalid[d] !== 1'b1 || rdata[d] !== init_of[d] || exp_rdata !== init_of[d]) begin
      errors++;
      $display("FAIL reclear dut%0d: rvalid=%b rdata=%h, expected 1 %h", d, rvalid[d], rdata[d], init_of[d]);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0; wdata[d] = 8'h00; cyc[d] = 0;
    end
    addr_a = '0;
    addr_b = '0;
    #1;
    rst_n[0] = 1'b0;
    rst_n[1] = 1'b0;
    model_reset(0);
    model_reset(1);

    test_reset(0);
    test_init(0, 1'b1);
    test_clear_contents(0, 16);
    test_out_of_range(0);
    test_random(0, 200, 31);
    test_reset_inflight(0);

    test_reset(1);
    test_init(1, 1'b1);
    test_clear_contents(1, 32);
    test_read_after_write(1);
    test_back_to_back(1);
    test_out_of_range(1);
    test_random(1, 300, 1100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
